// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: opcodes and operand-source encodings shared by the 5-stage pipeline blocks
package rv_pipe_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] SRC_RF = 2'd0;
  localparam logic [1:0] SRC_X  = 2'd1;
  localparam logic [1:0] SRC_M  = 2'd2;
  localparam logic [1:0] SRC_W  = 2'd3;
endpackage

// File: rtl/inst_reg_decode.sv
// inst_reg_decode: extracts register fields and read/write usage from one instruction
module inst_reg_decode
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] inst,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            writes_rd,
  output logic            is_load
);
  logic [6:0] op;
  logic unused_bits;
  assign op        = inst[6:0];
  assign rs1       = inst[19:15];
  assign rs2       = inst[24:20];
  assign rd        = inst[11:7];
  assign writes_rd = op inside {OP_R, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  assign uses_rs1  = op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  assign uses_rs2  = op inside {OP_R, OP_STORE, OP_BRANCH};
  assign is_load   = op == OP_LOAD;
  assign unused_bits = ^{inst[XLEN-1:25], inst[14:12]};
endmodule

// File: rtl/stall_bypass_unit.sv
// stall_bypass_unit: operand bypass selects, load-use stall and per-stage kill flags.
// WB_BYPASS_EN enables W-stage forwarding; without it a W-only match stalls D instead.
module stall_bypass_unit
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instD,
  input  logic [XLEN-1:0] instX,
  input  logic [XLEN-1:0] instM,
  input  logic [XLEN-1:0] instW,
  input  logic            alumux1,
  input  logic            alumux2,
  input  logic            predict_fail,
  output logic [1:0]      ASrc,
  output logic [1:0]      BSrc,
  output logic            stall,
  output logic            killF,
  output logic            killD,
  output logic            killX,
  output logic            killM,
  output logic            killW
);
  logic [3:0][XLEN-1:0] inst;
  logic [3:0][4:0] rs1, rs2, rd;
  logic [3:0] u1, u2, wr, ld, vp, kp;
  logic [3:0] am, bm;
  logic cd, use_a, use_b, sb, load_use, wb_hit;
  logic unused_ok;
  assign inst = {instW, instM, instX, instD};
  assign kp   = {killW, killM, killX, killD};
  for (genvar g = 0; g < 4; g++) begin : g_dec
    inst_reg_decode #(.XLEN(XLEN)) u_dec (
      .inst(inst[g]), .rs1(rs1[g]), .rs2(rs2[g]), .rd(rd[g]),
      .uses_rs1(u1[g]), .uses_rs2(u2[g]), .writes_rd(wr[g]), .is_load(ld[g])
    );
    assign vp[g] = wr[g] && !kp[g] && rd[g] != 5'd0;
    assign am[g] = vp[g] && rd[g] == rs1[0];
    assign bm[g] = vp[g] && rd[g] == rs2[0];
  end
`ifdef WB_BYPASS_EN
  localparam logic [1:0] W_SRC = SRC_W;
  assign wb_hit = 1'b0;
`else
  localparam logic [1:0] W_SRC = SRC_RF;
  assign wb_hit = cd && ((u1[0] && am[3] && !am[1] && !am[2]) ||
                         (u2[0] && bm[3] && !bm[1] && !bm[2]));
`endif
  assign cd       = !killD;
  assign sb       = instD[6:0] inside {OP_STORE, OP_BRANCH};
  assign use_a    = cd && u1[0] && !alumux1;
  assign use_b    = cd && u2[0] && (!alumux2 || sb);
  assign load_use = cd && ld[1] && ((u1[0] && am[1]) || (u2[0] && bm[1]));
  assign unused_ok = ^{rs1[3:1], rs2[3:1], u1[3:1], u2[3:1], ld[3:2], ld[0], wr[0], rd[0], vp[0], am[0], bm[0]};
  always_comb begin
    stall = load_use || wb_hit;
    ASrc  = (stall || !use_a) ? SRC_RF : am[1] ? SRC_X : am[2] ? SRC_M : am[3] ? W_SRC : SRC_RF;
    BSrc  = (stall || !use_b) ? SRC_RF : bm[1] ? SRC_X : bm[2] ? SRC_M : bm[3] ? W_SRC : SRC_RF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      killF <= 1'b0;
      killD <= 1'b1;
      killX <= 1'b1;
      killM <= 1'b1;
      killW <= 1'b1;
    end else begin
      killF <= (stall && !predict_fail) ? killF : 1'b0;
      killD <= predict_fail ? 1'b1 : stall ? killD : killF;
      killX <= (predict_fail || stall) ? 1'b1 : killD;
      killM <= killX;
      killW <= killM;
    end
  end
endmodule

// File: tb/tb_stall_bypass_unit.sv
// tb_stall_bypass_unit: directed vectors, expectations queued and checked by a negedge monitor
module tb_stall_bypass_unit;
  typedef struct {
    string      name;
    logic [1:0] a;
    logic [1:0] b;
    logic       s;
    logic [4:0] k;
  } exp_t;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] ADD_3_12 = 32'h0020_81B3;
  localparam logic [31:0] ADD_3_00 = 32'h0000_01B3;
  localparam logic [31:0] ADD_7_50 = 32'h0002_83B3;
  localparam logic [31:0] ADDI_X1  = 32'h0050_0093;
  localparam logic [31:0] ADDI_X2  = 32'h0050_0113;
  localparam logic [31:0] ADDI_X0  = 32'h0050_0013;
  localparam logic [31:0] ADDI_X9  = 32'h0050_0493;
  localparam logic [31:0] SW_2_1   = 32'h0020_A023;
  localparam logic [31:0] LW_5_6   = 32'h0003_2283;
  localparam logic [31:0] BEQ_9_0  = 32'h0004_8063;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] instD = NOP, instX = NOP, instM = NOP, instW = NOP;
  logic alumux1 = 1'b0, alumux2 = 1'b0, predict_fail = 1'b0;
  logic [1:0] ASrc, BSrc;
  logic stall, killF, killD, killX, killM, killW;
  exp_t q[$];
  int errors = 0, checks = 0;
  stall_bypass_unit dut (
    .clk(clk), .rst(rst), .instD(instD), .instX(instX), .instM(instM), .instW(instW),
    .alumux1(alumux1), .alumux2(alumux2), .predict_fail(predict_fail),
    .ASrc(ASrc), .BSrc(BSrc), .stall(stall),
    .killF(killF), .killD(killD), .killX(killX), .killM(killM), .killW(killW)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [31:0] d, x, m, w);
    instD = d; instX = x; instM = m; instW = w;
  endtask
  task automatic expect_out(input string nm, input logic [1:0] a, b, input logic s, input logic [4:0] k);
    exp_t e;
    e.name = nm; e.a = a; e.b = b; e.s = s; e.k = k;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [4:0] kg;
      e = q.pop_front();
      kg = {killF, killD, killX, killM, killW};
      checks += 4;
      if (ASrc !== e.a) begin errors++; $display("FAIL %s ASrc got=%0d want=%0d", e.name, ASrc, e.a); end
      if (BSrc !== e.b) begin errors++; $display("FAIL %s BSrc got=%0d want=%0d", e.name, BSrc, e.b); end
      if (stall !== e.s) begin errors++; $display("FAIL %s stall got=%0b want=%0b", e.name, stall, e.s); end
      if (kg !== e.k) begin errors++; $display("FAIL %s kills(FDXMW) got=%05b want=%05b", e.name, kg, e.k); end
    end
  end
  initial begin
    cyc(1);
    expect_out("reset", 0, 0, 0, 5'b01111);
    rst = 1'b0;
    cyc(4);
    expect_out("drained", 0, 0, 0, 5'b00000);
    cyc(1);
    set(ADD_3_12, ADDI_X1, NOP, NOP);
    expect_out("x_fwd", 1, 0, 0, 5'b00000);
    cyc(1);
    set(ADD_3_12, ADDI_X1, ADDI_X1, NOP);
    expect_out("x_over_m", 1, 0, 0, 5'b00000);
    cyc(1);
    set(ADD_3_12, ADDI_X1, ADDI_X2, ADDI_X2);
    expect_out("m_over_w", 1, 2, 0, 5'b00000);
    cyc(1);
    alumux1 = 1'b1; alumux2 = 1'b1;
    expect_out("alumux_mask", 0, 0, 0, 5'b00000);
    cyc(1);
    set(SW_2_1, ADDI_X1, ADDI_X2, NOP);
    alumux1 = 1'b0;
    expect_out("store_rs2", 1, 2, 0, 5'b00000);
    cyc(1);
    alumux2 = 1'b0;
    set(ADD_3_00, ADDI_X0, ADDI_X0, ADDI_X0);
    expect_out("x0_no_fwd", 0, 0, 0, 5'b00000);
    cyc(1);
    set(ADD_3_12, ADDI_X1, NOP, NOP);
    predict_fail = 1'b1;
    cyc(1);
    predict_fail = 1'b0;
    expect_out("killd_consumer", 0, 0, 0, 5'b01100);
    cyc(1);
    expect_out("killx_producer", 0, 0, 0, 5'b00110);
    set(NOP, NOP, NOP, NOP);
    cyc(3);
    expect_out("redrained", 0, 0, 0, 5'b00000);
    cyc(1);
    set(ADD_7_50, LW_5_6, NOP, NOP);
    expect_out("load_use", 0, 0, 1, 5'b00000);
    cyc(1);
    set(NOP, NOP, NOP, NOP);
    expect_out("after_stall", 0, 0, 0, 5'b00100);
    cyc(1);
    set(ADD_7_50, LW_5_6, NOP, NOP);
    predict_fail = 1'b1;
    expect_out("pf_with_stall", 0, 0, 1, 5'b00010);
    cyc(1);
    predict_fail = 1'b0;
    expect_out("after_pf", 0, 0, 0, 5'b01101);
    set(NOP, NOP, NOP, NOP);
    cyc(4);
    expect_out("drained3", 0, 0, 0, 5'b00000);
    cyc(1);
    set(BEQ_9_0, NOP, NOP, ADDI_X9);
`ifdef WB_BYPASS_EN
    expect_out("w_path", 3, 0, 0, 5'b00000);
`else
    expect_out("w_path", 0, 0, 1, 5'b00000);
`endif
    cyc(1);
    set(NOP, NOP, NOP, NOP);
`ifdef WB_BYPASS_EN
    expect_out("after_w", 0, 0, 0, 5'b00000);
`else
    expect_out("after_w", 0, 0, 0, 5'b00100);
`endif
    cyc(1);
    rst = 1'b1; predict_fail = 1'b1;
    cyc(1);
    rst = 1'b0; predict_fail = 1'b0;
    expect_out("mid_reset", 0, 0, 0, 5'b01111);
    cyc(2);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL queue_drain pending=%0d want=0", q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stall_bypass_unit.md
Name: stall_bypass_unit

Overview:
Hazard unit for the 5-stage RISC-V pipeline (F, D, X, M, W).
- Combinationally decodes source/destination registers of the D, X, M and W instructions.
- Produces operand-bypass selects (ASrc/BSrc) and a load-use stall for the D-stage operand muxes.
- Owns the registered per-stage kill (bubble) flags, updated on stalls and branch mispredictions.
- Sits beside the per-stage control decoders and the static branch predictor.

Parameters:
XLEN, 32, instruction width in bits; only 32 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
instD  input  32  instruction in Decode
instX  input  32  instruction in Execute
instM  input  32  instruction in Memory
instW  input  32  instruction in Writeback
alumux1  input  1  D-stage ASel: 1 means operand A is the PC, so no rs1 hazard
alumux2  input  1  D-stage BSel: 1 means operand B is the immediate, so no rs2 hazard unless the instruction is a STORE or BRANCH
predict_fail  input  1  branch resolved in X disagrees with the prediction
ASrc  output  2  operand A source: 0 regfile, 1 X ALU result, 2 M writeback data, 3 W writeback data
BSrc  output  2  operand B / store-data source, same encoding as ASrc
stall  output  1  hold F and D this cycle; combinational
killF, killD, killX, killM, killW  output  1 each  registered: the instruction in that stage is a bubble

Behaviour:
Register-use decode (opcode = inst[6:0]):
- Writes rd = inst[11:7] for R 0110011, I-ALU 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- Reads rs1 = inst[19:15] for R, I-ALU, LOAD, STORE 0100011, BRANCH 1100011, JALR.
- Reads rs2 = inst[24:20] for R, STORE, BRANCH.
- rd = x0 never matches. Unknown opcodes neither read nor write.

Qualification: a producer in stage S is valid only if it writes rd and killS = 0. A consumer is valid only if killD = 0.

ASrc (rs1), evaluated in priority order:
- alumux1 = 1 or rs1 not read: 0.
- Valid producer in X with matching rd: 1.
- Else valid producer in M: 2.
- Else valid producer in W: 3.
- Else: 0.

BSrc: same rule using rs2. alumux2 = 1 forces 0 except for STORE and BRANCH, which still require rs2.

stall = 1 when valid instD reads a register matched by a valid LOAD in X (load-use). While stall = 1, ASrc/BSrc are don't-care but must be driven (force 0).

Kill flags, updated on the clock edge:
- rst: killF = 0; killD, killX, killM, killW = 1.
- predict_fail = 1 (has priority over stall): killF = 0, killD = 1, killX = 1, killM = old killX, killW = old killM.
- Else if stall: killF and killD hold; killX = 1; killM = old killX; killW = old killM.
- Else shift: killF = 0, killD = old killF, killX = old killD, killM = old killX, killW = old killM.
- rst asserted mid-operation overrides everything in the same cycle.

stall and the bypass selects are purely combinational, with zero latency from the inst inputs and kill flags.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: W-stage forwarding (source 3) is enabled as above.
- Undefined: a W-stage match never forwards. It instead raises stall for that cycle, and the regfile write lands before D reads again. Source code 3 is never produced.

Decomposition:
Shared package rv_pipe_pkg holds:
- opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
- source encodings SRC_RF=0, SRC_X=1, SRC_M=2, SRC_W=3.

One sub-module, inst_reg_decode (inst -> rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, is_load), instantiated four times.

Test Plan:
- Reset: rst=1 for one cycle -> killF=0, killD..killW=1, stall=0.
- X forward: instD add x3,x1,x2, instX addi x1,x0,5 (all unkilled) -> ASrc=1, BSrc=0, stall=0. Same with killX=1 -> ASrc=0.
- Priority and x0:
  - instX and instM both write x1, instD reads x1 -> ASrc=1.
  - instM writes x2 and instW writes x2 -> BSrc=2.
  - Any stage writing x0 -> no forward.
- Load-use: instX lw x5,0(x6), instD add x7,x5,x0 -> stall=1. Next edge: killX=1, killF and killD unchanged.
- Mispredict: predict_fail=1 with stall also 1 -> next cycle killD=1, killX=1, killF=0, killM=old killX.
- W path: instW writes x9, instD beq x9,x0:
  - with WB_BYPASS_EN: ASrc=3, stall=0;
  - without WB_BYPASS_EN: stall=1, ASrc=0.
